// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates a single-port memory between the control unit (Cpu*) and a
//   loader (Ld*). One access at a time: IDLE samples requests, ACCESS drives
//   the memory strobes for one cycle, WAIT (reads only) captures MemRData, and
//   DONE pulses the owner's Done for one cycle before returning to IDLE.
//   Ties alternate by last owner; LdLock reserves the port for the loader.
//
// Ports
//   CLK, Reset_n               clock, synchronous active-low reset
//   CpuReq/CpuWe/CpuAddr/CpuWData   control-unit request
//   CpuGnt/CpuDone/CpuStall         control-unit grant, completion, stall
//   LdReq/LdWe/LdLock/LdAddr/LdWData loader request and exclusive hold
//   LdGnt/LdDone                    loader grant, completion
//   RdData                          last read result
//   MemAddr/MemWData/MemRead/MemWrite/MemRData  memory side
//   Busy                            high whenever not IDLE
module mem_port_arbiter #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
) (
  input  logic          CLK,
  input  logic          Reset_n,
  input  logic          CpuReq,
  input  logic          CpuWe,
  input  logic [AW-1:0] CpuAddr,
  input  logic [DW-1:0] CpuWData,
  output logic          CpuGnt,
  output logic          CpuDone,
  output logic          CpuStall,
  input  logic          LdReq,
  input  logic          LdWe,
  input  logic          LdLock,
  input  logic [AW-1:0] LdAddr,
  input  logic [DW-1:0] LdWData,
  output logic          LdGnt,
  output logic          LdDone,
  output logic [DW-1:0] RdData,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  output logic          MemRead,
  output logic          MemWrite,
  input  logic [DW-1:0] MemRData,
  output logic          Busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;
  typedef enum logic {OWN_CPU, OWN_LD} owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  owner_e        last_q,  last_d;
  logic          we_q,    we_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic cpu_win, ld_win;

  // Lock overrides fairness; otherwise a tie goes to whoever did not own last.
  // The two terms are mutually exclusive by construction.
  assign ld_win  = LdReq  & (LdLock | ~CpuReq | (last_q == OWN_CPU));
  assign cpu_win = CpuReq & ~LdLock & (~LdReq | (last_q == OWN_LD));

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    MemAddr  = '0;
    MemWData = '0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    CpuDone  = 1'b0;
    LdDone   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_win) begin
          state_d = ACCESS;
          owner_d = OWN_LD;
          we_d    = LdWe;
          addr_d  = LdAddr;
          wdata_d = LdWData;
        end else if (cpu_win) begin
          state_d = ACCESS;
          owner_d = OWN_CPU;
          we_d    = CpuWe;
          addr_d  = CpuAddr;
          wdata_d = CpuWData;
        end
      end
      ACCESS: begin
        MemAddr  = addr_q;
        MemWData = wdata_q;
        MemWrite = we_q;
        MemRead  = ~we_q;
        state_d  = we_q ? DONE : WAIT;
      end
      WAIT: begin
        rdata_d = MemRData;
        state_d = DONE;
      end
      DONE: begin
        CpuDone = (owner_q == OWN_CPU);
        LdDone  = (owner_q == OWN_LD);
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Busy     = (state_q != IDLE);
  assign CpuGnt   = Busy & (owner_q == OWN_CPU);
  assign LdGnt    = Busy & (owner_q == OWN_LD);
  assign CpuStall = CpuReq & ~CpuDone;
  assign RdData   = rdata_q;

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      owner_q <= OWN_CPU;
      last_q  <= OWN_LD;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter. A transaction-level reference model
// (owner, age since grant, latency per access type) plus a reference memory
// predicts every output each cycle. A separate behavioural memory answers the
// DUT's strobes, so read data checks the full address/data path.
module tb_mem_port_arbiter;

  localparam int unsigned NCYC = 3000;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic        CpuReq, CpuWe, LdReq, LdWe, LdLock;
  logic [15:0] CpuAddr, CpuWData, LdAddr, LdWData;
  logic        CpuGnt, CpuDone, CpuStall, LdGnt, LdDone;
  logic [15:0] RdData, MemAddr, MemWData, MemRData;
  logic        MemRead, MemWrite, Busy;

  mem_port_arbiter #(.AW(16), .DW(16)) dut (
    .CLK(CLK), .Reset_n(Reset_n),
    .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuGnt(CpuGnt), .CpuDone(CpuDone), .CpuStall(CpuStall),
    .LdReq(LdReq), .LdWe(LdWe), .LdLock(LdLock), .LdAddr(LdAddr), .LdWData(LdWData),
    .LdGnt(LdGnt), .LdDone(LdDone), .RdData(RdData),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemRData(MemRData), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] init_val(int unsigned i);
    return 16'((i * 32'h0F1D) ^ 32'h5A3C);
  endfunction

  // Behavioural single-port memory driven by the DUT; data returned the cycle
  // after MemRead, junk otherwise.
  logic [15:0] pmem [256];
  bit          pmem_init = 1'b0;
  always @(posedge CLK) begin
    if (!pmem_init) begin
      for (int unsigned i = 0; i < 256; i++) pmem[i] <= init_val(i);
      pmem_init <= 1'b1;
      MemRData  <= 16'($urandom);
    end else begin
      if (MemWrite) pmem[MemAddr[7:0]] <= MemWData;
      MemRData <= MemRead ? pmem[MemAddr[7:0]] : 16'($urandom);
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got=%h expected=%h", tag, $time, got, exp);
  endtask

  // Reference model state
  logic [15:0] rmem [256];
  bit          m_busy, m_own_ld, m_we, m_last_ld, m_rst;
  int unsigned m_age;
  logic [15:0] m_addr, m_wd, m_rd;

  function automatic int unsigned m_len();
    return m_we ? 2 : 3;  // write: ACCESS,DONE  read: ACCESS,WAIT,DONE
  endfunction

  task automatic compare();
    bit acc, done;
    acc  = m_busy && (m_age == 1);
    done = m_busy && (m_age == m_len());
    check_eq("busy",     Busy,     m_busy);
    check_eq("cpu_gnt",  CpuGnt,   m_busy && !m_own_ld);
    check_eq("ld_gnt",   LdGnt,    m_busy && m_own_ld);
    check_eq("cpu_done", CpuDone,  done && !m_own_ld);
    check_eq("ld_done",  LdDone,   done && m_own_ld);
    check_eq("mem_read", MemRead,  acc && !m_we);
    check_eq("mem_write",MemWrite, acc && m_we);
    check_eq("strobe_excl", MemRead & MemWrite, 0);
    check_eq("rd_data",  RdData,   m_rd);
    check_eq("cpu_stall",CpuStall, CpuReq && !(done && !m_own_ld));
    if (acc || m_rst) begin
      check_eq("mem_addr",  MemAddr,  acc ? m_addr : 16'h0);
      check_eq("mem_wdata", MemWData, acc ? m_wd   : 16'h0);
    end
  endtask

  task automatic model_step();
    bit cw, lw;
    if (!Reset_n) begin
      m_busy = 0; m_last_ld = 1; m_rd = '0; m_rst = 1;
    end else begin
      m_rst = 0;
      if (m_busy) begin
        if (m_age == m_len()) begin
          m_busy = 0;
          m_last_ld = m_own_ld;
        end else begin
          m_age++;
          if (!m_we && m_age == 3) m_rd = rmem[m_addr[7:0]];
        end
      end else begin
        lw = LdReq && (LdLock || !CpuReq || !m_last_ld);
        cw = CpuReq && !LdLock && (!LdReq || m_last_ld);
        if (lw || cw) begin
          m_busy = 1; m_age = 1; m_own_ld = lw;
          m_we   = lw ? LdWe    : CpuWe;
          m_addr = lw ? LdAddr  : CpuAddr;
          m_wd   = lw ? LdWData : CpuWData;
          if (m_we) rmem[m_addr[7:0]] = m_wd;
        end
      end
    end
  endtask

  initial begin
    for (int unsigned i = 0; i < 256; i++) rmem[i] = init_val(i);
    Reset_n = 1'b0;
    CpuReq = 0; CpuWe = 0; CpuAddr = '0; CpuWData = '0;
    LdReq = 0; LdWe = 0; LdLock = 0; LdAddr = '0; LdWData = '0;
    m_busy = 0; m_last_ld = 1; m_rd = '0; m_rst = 1; m_age = 0;
    m_own_ld = 0; m_we = 0; m_addr = '0; m_wd = '0;

    for (int unsigned cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge CLK);
      compare();
      Reset_n  = (cyc < 3) ? 1'b0 : ($urandom_range(0, 59) != 0);
      CpuReq   = ($urandom_range(0, 9) < 7);
      CpuWe    = $urandom_range(0, 1) != 0;
      CpuAddr  = 16'($urandom_range(0, 15));
      CpuWData = 16'($urandom);
      LdReq    = ($urandom_range(0, 9) < 6);
      LdWe     = $urandom_range(0, 1) != 0;
      LdLock   = (cyc >= 1000 && cyc < 1400) ? ($urandom_range(0, 9) < 8)
                                             : ($urandom_range(0, 9) == 0);
      LdAddr   = 16'($urandom_range(0, 15));
      LdWData  = 16'($urandom);
      model_step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: AW, 16, address width; DW, 16, data width.
REQ-002 CLK  in  1  sole clock; all state changes on rising edge.
REQ-003 Reset_n  in  1  reset, synchronous, active-low.
REQ-004 CpuReq / CpuWe  in  1 / 1  control-unit request; We=1 write, We=0 read.
REQ-005 CpuAddr / CpuWData  in  AW / DW  control-unit address and write data.
REQ-006 CpuGnt / CpuDone / CpuStall  out  1 each  CPU owns port; one-cycle completion pulse; stall to control unit.
REQ-007 LdReq / LdWe / LdLock  in  1 each  loader request; loader write enable; loader exclusive-hold of port.
REQ-008 LdAddr / LdWData  in  AW / DW  loader address and write data.
REQ-009 LdGnt / LdDone  out  1 / 1  loader owns port; one-cycle completion pulse.
REQ-010 RdData  out  DW  read result, valid only while the owner's Done is high.
REQ-011 MemAddr / MemWData  out  AW / DW  to single-port memory.
REQ-012 MemRead / MemWrite  out  1 / 1  memory strobes; MemRData  in  DW, valid the cycle after MemRead.
REQ-013 Busy  out  1  high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ACCESS, WAIT, DONE.
REQ-015 In IDLE, requests are sampled; on a grant, owner, We, Addr, WData latch and the FSM goes to ACCESS on the same edge.
REQ-016 Arbitration: only one requester -> it wins. Both requesting -> the one not in LastOwner wins. LastOwner resets to Loader, so CPU wins the first tie.
REQ-017 LdLock=1 in IDLE blocks CPU grants; the loader is granted whenever LdReq=1.
REQ-018 Gnt of the owner SHALL be high from ACCESS through DONE inclusive and low otherwise.
REQ-019 ACCESS lasts exactly one cycle. It drives MemAddr/MemWData from the latched values, with MemWrite=We and MemRead=~We.
REQ-020 ACCESS -> WAIT for reads; ACCESS -> DONE for writes.
REQ-021 WAIT lasts one cycle with no strobes; RdData register loads MemRData at its end; -> DONE.
REQ-022 DONE lasts one cycle: owner's Done=1, LastOwner updates, -> IDLE.
REQ-023 Latency from sampling edge to Done high: write 1 cycle, read 2 cycles; max throughput one access per 3 (write) / 4 (read) cycles.
REQ-024 Requests are only sampled in IDLE. Changes to an owner's inputs after latching have no effect. Dropping Req mid-access does not abort it.
REQ-025 MemRead and MemWrite SHALL never be high together, and SHALL be 0 outside ACCESS.
REQ-026 CpuStall = CpuReq & ~CpuDone (combinational). It is also high while the loader owns the port.
REQ-027 Requester holding Req through DONE is re-arbitrated in the following IDLE, not auto-regranted.
REQ-028 RdData holds its last loaded value until the next read's WAIT; writes do not modify it.

Reset
REQ-029 On a rising edge with Reset_n=0: state=IDLE, LastOwner=Loader, RdData=0, latched regs=0.
REQ-030 During and after reset, all outputs SHALL be 0 except CpuStall, which follows REQ-026.
REQ-031 Reset mid-access abandons the transfer: no Done pulse, strobes low from the next cycle.

Verification
REQ-032 CPU read only: CpuReq=1, CpuWe=0, CpuAddr=0x0010, MemRData=0xBEEF in WAIT -> MemRead=1 in ACCESS only; CpuDone high 2 cycles after sampling with RdData=0xBEEF.
REQ-033 Loader write only: LdReq=1, LdWe=1, LdAddr=0x0020, LdWData=0x1234 -> one-cycle MemWrite with those values; LdDone 1 cycle later; RdData unchanged.
REQ-034 Tie after reset: CpuReq=LdReq=1, both held -> CPU served first, then loader, then CPU (alternation); no strobe overlap.
REQ-035 LdLock=1 with both requesting continuously -> only LdGnt ever asserts; CpuStall=1 throughout; CPU is granted in the first IDLE after LdLock drops.
REQ-036 Reset_n=0 asserted during WAIT of a CPU read -> next cycle IDLE, CpuDone never pulses, Busy=0, RdData=0.
